matrix_result_collector: RTL
============================

Name: matrix_result_collector

Overview:
- Consumer end of the sequential multiplier's result interface (z_out/z_i/z_j/z_stb/z_ack).
- Accepts each strobed result word and writes it into an internal M×M result store at (z_i, z_j), one-pulse acknowledge per word.
- The last write to an element wins, so per-k partial sums are overwritten by the final sum.
- On the producer's done pulse, streams the full matrix out row-major over a stb/ack handshake, then pulses stream_done.

Parameters:
- M, 4, matrix dimension (M×M elements).
- DW, 32, element width in bits (IEEE-754 single).
- IW, max(1, clog2(M)), index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- z_in  in  DW  result word from producer
- z_i  in  IW  row index of z_in
- z_j  in  IW  column index of z_in
- z_stb  in  1  producer strobe: z_in/z_i/z_j valid
- z_ack  out  1  one-cycle acknowledge of a captured word
- mult_done  in  1  producer done pulse (one cycle)
- clear  in  1  zero the whole store (honoured in S_COLLECT only)
- out_data  out  DW  store element at (out_i, out_j)
- out_i  out  IW  row of out_data
- out_j  out  IW  column of out_data
- out_stb  out  1  out_data valid
- out_ack  in  1  downstream accept
- stream_done  out  1  one-cycle pulse after the last element is accepted
- busy  out  1  high in S_STREAM and S_FINISH

Behaviour:
- Reset (async, rst=1):
  - State S_COLLECT; store zeroed.
  - z_ack=0, out_stb=0, out_i=out_j=0, stream_done=0, busy=0, done_pend=0.
  - Reset mid-capture or mid-stream abandons the operation fully; no partial stream_done.
- States: S_COLLECT, S_WAIT_LOW, S_STREAM, S_FINISH.
- S_COLLECT:
  - If z_stb=1: store[z_i][z_j] <= z_in; z_ack <= 1; go to S_WAIT_LOW.
  - Else if clear=1: all elements <= 0; stay.
  - Else if mult_done=1 or done_pend=1: done_pend <= 0; out_i <= 0; out_j <= 0; out_stb <= 1; go to S_STREAM.
  - Priority: z_stb > clear > done.
- S_WAIT_LOW:
  - z_ack <= 0, so z_ack is high for exactly one cycle per word.
  - Stay until z_stb is sampled 0, then go to S_COLLECT. This prevents double capture of a held strobe.
  - mult_done seen here sets done_pend.
- S_STREAM:
  - out_data is combinational read of store[out_i][out_j].
  - On a cycle with out_stb=1 and out_ack=1, advance row-major: out_j+1; at out_j=M-1 wrap out_j to 0 and out_i+1.
  - When the accepted element is (M-1, M-1): out_stb <= 0, indices <= 0, go to S_FINISH.
  - With out_ack held high, throughput is one element per cycle; M*M accepts total.
  - out_ack while out_stb=0 is ignored.
  - z_stb is not acknowledged (z_ack stays 0); the producer stalls until S_COLLECT.
  - clear is ignored.
  - mult_done sets done_pend and causes a second stream afterwards.
- S_FINISH: stream_done <= 1 for one cycle; go to S_COLLECT. The store is retained, not cleared.
- Out-of-range indices (z_i or z_j >= M when M is not a power of 2): the word is acknowledged but the write is dropped.
- Latency:
  - z_stb high to z_ack high: 1 cycle.
  - mult_done to out_stb high: 1 cycle.
  - Final accept to stream_done: 1 cycle.

Test Plan:
- M=4, reset, then write (1,2)=0x3F800000, 0x40000000, 0x40400000 in turn, each stb held until ack, then mult_done. Required: each ack is a single-cycle pulse and the stream element at out_i=1, out_j=2 is 0x40400000. All other elements are 0. The stream is 16 words in row-major order.
- Write all 16 elements with value 0x41000000+4i+j; mult_done; out_ack tied 1. Required: 16 consecutive out_stb cycles, values in order, stream_done one cycle after the 16th accept, busy low after.
- Streaming with out_ack toggling 1,0,0,1… Required: out_data/out_i/out_j hold stable while out_ack=0; exactly 16 accepts; no skipped or duplicated index.
- z_stb held high for 3 cycles with z_in=0x3F800000 at (0,0). Required: single capture, z_ack high exactly 1 cycle, no second ack until z_stb returns to 0 and rises again.
- mult_done pulsed during S_WAIT_LOW. Required: done_pend is honoured and the stream starts after z_stb drops.
- z_stb asserted during a stream. Required: no z_ack until S_COLLECT, then capture.
- rst pulsed after 5 accepted stream elements. Required: out_stb=0 and no stream_done; store reads back all 0 on the next stream.

Source files
------------

// File: rtl/matrix_result_collector.sv
// matrix_result_collector: consumer end of the sequential multiplier's result
// interface. Captures strobed result words into an M x M store (last write
// wins). When the producer signals done, it streams the whole matrix out in
// row-major order and then pulses stream_done.
//
// Handshakes: on the input side a word is taken on the first cycle z_stb is
// sampled high in S_COLLECT and answered with a one-cycle z_ack. The strobe
// must then be sampled low before another word can be taken. On the output
// side an element transfers on every cycle where out_stb and out_ack are both
// high. While out_stb is high and out_ack is low, out_data/out_i/out_j hold.
module matrix_result_collector #(
  parameter int M  = 4,
  parameter int DW = 32,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] z_in,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  input  logic          mult_done,
  input  logic          clear,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_i,
  output logic [IW-1:0] out_j,
  output logic          out_stb,
  input  logic          out_ack,
  output logic          stream_done,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_WAIT_LOW = 2'd1,
    S_STREAM   = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  state_t        state_q;
  logic [DW-1:0] store_q [M][M];
  logic          z_ack_q;
  logic          out_stb_q;
  logic          stream_done_q;
  logic          done_pend_q;
  logic [IW-1:0] out_i_q;
  logic [IW-1:0] out_j_q;
  logic [IW-1:0] out_i_d;
  logic [IW-1:0] out_j_d;

  logic z_in_range;
  logic wr_en;
  logic clr_en;
  logic accept;
  logic last_elem;

  // Indices outside the matrix are acknowledged but never written.
  assign z_in_range = ({{(32-IW){1'b0}}, z_i} < 32'(M)) &&
                      ({{(32-IW){1'b0}}, z_j} < 32'(M));
  assign wr_en      = (state_q == S_COLLECT) && z_stb && z_in_range;
  assign clr_en     = (state_q == S_COLLECT) && !z_stb && clear;
  assign accept     = out_stb_q && out_ack;
  assign last_elem  = (out_i_q == LAST_IDX) && (out_j_q == LAST_IDX);

  // Row-major successor of the element currently presented.
  always_comb begin
    out_i_d = out_i_q;
    out_j_d = out_j_q + IW'(1);
    if (out_j_q == LAST_IDX) begin
      out_j_d = '0;
      out_i_d = out_i_q + IW'(1);
    end
  end

  // Result store: zeroed by reset or clear, otherwise last write wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < M; c++) begin
          store_q[r][c] <= '0;
        end
      end
    end else if (clr_en) begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < M; c++) begin
          store_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      store_q[z_i][z_j] <= z_in;
    end
  end

  // Control FSM: capture, wait for strobe release, stream, finish pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_COLLECT;
      z_ack_q       <= 1'b0;
      out_stb_q     <= 1'b0;
      out_i_q       <= '0;
      out_j_q       <= '0;
      stream_done_q <= 1'b0;
      done_pend_q   <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (z_stb) begin
            z_ack_q <= 1'b1;
            state_q <= S_WAIT_LOW;
            // A done pulse that loses on priority is remembered, not dropped.
            if (mult_done) done_pend_q <= 1'b1;
          end else if (clear) begin
            if (mult_done) done_pend_q <= 1'b1;
          end else if (mult_done || done_pend_q) begin
            done_pend_q <= 1'b0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_stb_q   <= 1'b1;
            state_q     <= S_STREAM;
          end
        end
        S_WAIT_LOW: begin
          z_ack_q <= 1'b0;
          if (mult_done) done_pend_q <= 1'b1;
          if (!z_stb) state_q <= S_COLLECT;
        end
        S_STREAM: begin
          if (mult_done) done_pend_q <= 1'b1;
          if (accept) begin
            if (last_elem) begin
              out_stb_q     <= 1'b0;
              out_i_q       <= '0;
              out_j_q       <= '0;
              stream_done_q <= 1'b1;
              state_q       <= S_FINISH;
            end else begin
              out_i_q <= out_i_d;
              out_j_q <= out_j_d;
            end
          end
        end
        S_FINISH: begin
          stream_done_q <= 1'b0;
          if (mult_done) done_pend_q <= 1'b1;
          state_q <= S_COLLECT;
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign z_ack       = z_ack_q;
  assign out_stb     = out_stb_q;
  assign out_i       = out_i_q;
  assign out_j       = out_j_q;
  assign out_data    = store_q[out_i_q][out_j_q];
  assign stream_done = stream_done_q;
  assign busy        = (state_q == S_STREAM) || (state_q == S_FINISH);

endmodule
